// File: rtl/decode_sequencer_pkg.sv
// Shared decode definitions: opcodes, funct3 codes, ALU operations, operand/immediate selectors,
// step counts and the per-uop control bundle.
package decode_sequencer_pkg;

  localparam int unsigned ALU_OP_WIDTH = 5;
  localparam int unsigned JUMP_STEPS   = 2;
  localparam int unsigned BRANCH_STEPS = 2;

  localparam logic [6:0] OPCODE_LOAD    = 7'h03;
  localparam logic [6:0] OPCODE_CUSTOM0 = 7'h0b;
  localparam logic [6:0] OPCODE_OPIMM   = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC   = 7'h17;
  localparam logic [6:0] OPCODE_STORE   = 7'h23;
  localparam logic [6:0] OPCODE_OP      = 7'h33;
  localparam logic [6:0] OPCODE_LUI     = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH  = 7'h63;
  localparam logic [6:0] OPCODE_JALR    = 7'h67;
  localparam logic [6:0] OPCODE_JAL     = 7'h6f;
  localparam logic [6:0] OPCODE_SYSTEM  = 7'h73;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;
  localparam logic [2:0] FUNCT3_PRIV = 3'b000;

  // ALU_AND is zero so an all-zero control bundle is the idle value.
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND    = 5'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = 5'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB    = 5'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR    = 5'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR     = 5'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL    = 5'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA    = 5'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT    = 5'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU   = 5'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ     = 5'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE     = 5'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LT     = 5'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GE     = 5'd13;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU    = 5'd14;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU    = 5'd15;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL    = 5'd16;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULH   = 5'd17;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHSU = 5'd18;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHU  = 5'd19;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV    = 5'd20;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU   = 5'd21;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM    = 5'd22;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU   = 5'd23;

  localparam logic [2:0] IMM_NONE  = 3'd0;
  localparam logic [2:0] IMM_I     = 3'd1;
  localparam logic [2:0] IMM_S     = 3'd2;
  localparam logic [2:0] IMM_SB    = 3'd3;
  localparam logic [2:0] IMM_U     = 3'd4;
  localparam logic [2:0] IMM_UJ    = 3'd5;
  localparam logic [2:0] IMM_ZIMM  = 3'd6;
  localparam logic [2:0] IMM_PCINC = 3'd7;

  localparam logic [1:0] ALU_OP_SEL_A_RF   = 2'd0;
  localparam logic [1:0] ALU_OP_SEL_A_PC   = 2'd1;
  localparam logic [1:0] ALU_OP_SEL_A_ZERO = 2'd2;
  localparam logic       ALU_OP_SEL_B_RF   = 1'b0;
  localparam logic       ALU_OP_SEL_B_IMM  = 1'b1;

  localparam logic [1:0] RF_WRITE_ALU = 2'd0;
  localparam logic [1:0] RF_WRITE_LSU = 2'd1;
  localparam logic [1:0] RF_WRITE_CSR = 2'd2;

  localparam logic [1:0] CSR_OP_NONE  = 2'd0;
  localparam logic [1:0] CSR_OP_WRITE = 2'd1;
  localparam logic [1:0] CSR_OP_SET   = 2'd2;
  localparam logic [1:0] CSR_OP_CLEAR = 2'd3;

  localparam logic [1:0] DATA_BYTE = 2'd0;
  localparam logic [1:0] DATA_HALF = 2'd1;
  localparam logic [1:0] DATA_WORD = 2'd2;

  typedef struct packed {
    logic                    rf_we;
    logic [1:0]              rf_write_sel;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [1:0]              op_a_sel;
    logic                    op_b_sel;
    logic                    lsu_w_en;
    logic                    lsu_r_en;
    logic [1:0]              lsu_data_type;
    logic                    lsu_sign_extend;
    logic [1:0]              csr_op;
    logic [11:0]             csr_addr;
    logic                    mm_start;
    logic                    jump;
    logic                    branch;
    logic                    ecall;
    logic                    ebreak;
    logic                    mret;
    logic                    illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_sequencer_uop_decode.sv
// Combinational uop decoder: control bundle, register fields, immediate and step count for one
// (instruction, step) pair. Macro DECODE_M_EXT_EN enables the M-extension OP encodings.
module uop_decode
  import decode_sequencer_pkg::*;
#(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned MM_STEPS  = 4,
  parameter int unsigned XLEN      = 32
) (
  input  logic [XLEN-1:0] instr_i,
  input  logic [2:0]      step_i,
  input  logic            compressed_i,
  input  logic            illegal_compressed_i,
  output ctrl_t           ctrl_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] imm_o,
  output logic [3:0]      num_steps_o
);

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd, rs3, rs2_sel;
  logic        use_rs1, use_rs2, use_rd, use_rs3, bad_enc, reg_oob, illegal;
  logic [2:0]  imm_sel;
  logic [3:0]  num_steps;
  logic [31:0] imm32;
  ctrl_t       ctrl;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign rs3    = instr_i[31:27];
  assign funct7 = instr_i[31:25];

  always_comb begin
    ctrl      = '0;
    imm_sel   = IMM_NONE;
    num_steps = 4'd1;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    use_rs3   = 1'b0;
    bad_enc   = 1'b0;
    rs2_sel   = rs2;
    case (opcode)
      OPCODE_LUI, OPCODE_AUIPC: begin
        use_rd        = 1'b1;
        ctrl.rf_we    = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        ctrl.op_a_sel = (opcode == OPCODE_LUI) ? ALU_OP_SEL_A_ZERO : ALU_OP_SEL_A_PC;
        ctrl.op_b_sel = ALU_OP_SEL_B_IMM;
        imm_sel       = IMM_U;
      end
      OPCODE_OPIMM: begin
        use_rs1       = 1'b1;
        use_rd        = 1'b1;
        ctrl.rf_we    = 1'b1;
        ctrl.op_b_sel = ALU_OP_SEL_B_IMM;
        imm_sel       = IMM_I;
        case (funct3)
          FUNCT3_ADD_SUB: ctrl.alu_op = ALU_ADD;
          FUNCT3_SLT:     ctrl.alu_op = ALU_SLT;
          FUNCT3_SLTU:    ctrl.alu_op = ALU_SLTU;
          FUNCT3_XOR:     ctrl.alu_op = ALU_XOR;
          FUNCT3_OR:      ctrl.alu_op = ALU_OR;
          FUNCT3_AND:     ctrl.alu_op = ALU_AND;
          FUNCT3_SLL: begin
            ctrl.alu_op = ALU_SLL;
            bad_enc     = (funct7 != 7'h00);
          end
          default: begin
            ctrl.alu_op = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            bad_enc     = (funct7 != 7'h00) && (funct7 != 7'h20);
          end
        endcase
      end
      OPCODE_OP: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        use_rd     = 1'b1;
        ctrl.rf_we = 1'b1;
        case (funct7)
          7'h00: begin
            case (funct3)
              FUNCT3_ADD_SUB: ctrl.alu_op = ALU_ADD;
              FUNCT3_SLL:     ctrl.alu_op = ALU_SLL;
              FUNCT3_SLT:     ctrl.alu_op = ALU_SLT;
              FUNCT3_SLTU:    ctrl.alu_op = ALU_SLTU;
              FUNCT3_XOR:     ctrl.alu_op = ALU_XOR;
              FUNCT3_SRL_SRA: ctrl.alu_op = ALU_SRL;
              FUNCT3_OR:      ctrl.alu_op = ALU_OR;
              default:        ctrl.alu_op = ALU_AND;
            endcase
          end
          7'h20: begin
            case (funct3)
              FUNCT3_ADD_SUB: ctrl.alu_op = ALU_SUB;
              FUNCT3_SRL_SRA: ctrl.alu_op = ALU_SRA;
              default:        bad_enc = 1'b1;
            endcase
          end
`ifdef DECODE_M_EXT_EN
          // MUL..REMU codes follow funct3 order starting at ALU_MUL.
          7'h01: ctrl.alu_op = ALU_MUL | {2'b00, funct3};
`endif
          default: bad_enc = 1'b1;
        endcase
      end
      OPCODE_LOAD: begin
        use_rs1              = 1'b1;
        use_rd               = 1'b1;
        ctrl.rf_we           = 1'b1;
        ctrl.rf_write_sel    = RF_WRITE_LSU;
        ctrl.lsu_r_en        = 1'b1;
        ctrl.alu_op          = ALU_ADD;
        ctrl.op_b_sel        = ALU_OP_SEL_B_IMM;
        ctrl.lsu_data_type   = funct3[1:0];
        ctrl.lsu_sign_extend = ~funct3[2];
        imm_sel              = IMM_I;
        bad_enc              = (funct3[1:0] == 2'b11) || (funct3[2] && funct3[1]);
      end
      OPCODE_STORE: begin
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
        ctrl.lsu_w_en      = 1'b1;
        ctrl.alu_op        = ALU_ADD;
        ctrl.op_b_sel      = ALU_OP_SEL_B_IMM;
        ctrl.lsu_data_type = funct3[1:0];
        imm_sel            = IMM_S;
        bad_enc            = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPCODE_SYSTEM: begin
        if (funct3 == FUNCT3_PRIV) begin
          bad_enc = (rs1 != 5'd0) || (rd != 5'd0);
          case (instr_i[31:20])
            12'h000: ctrl.ecall  = 1'b1;
            12'h001: ctrl.ebreak = 1'b1;
            12'h302: ctrl.mret   = 1'b1;
            default: bad_enc     = 1'b1;
          endcase
        end else if (funct3 == 3'b100) begin
          bad_enc = 1'b1;
        end else begin
          use_rd            = 1'b1;
          use_rs1           = ~funct3[2];
          ctrl.rf_we        = 1'b1;
          ctrl.rf_write_sel = RF_WRITE_CSR;
          ctrl.csr_op       = funct3[1:0];
          ctrl.csr_addr     = instr_i[31:20];
          ctrl.op_b_sel     = funct3[2] ? ALU_OP_SEL_B_IMM : ALU_OP_SEL_B_RF;
          imm_sel           = funct3[2] ? IMM_ZIMM : IMM_NONE;
        end
      end
      OPCODE_JAL, OPCODE_JALR: begin
        use_rd        = 1'b1;
        use_rs1       = (opcode == OPCODE_JALR);
        bad_enc       = (opcode == OPCODE_JALR) && (funct3 != 3'b000);
        num_steps     = 4'(JUMP_STEPS);
        ctrl.jump     = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        ctrl.op_b_sel = ALU_OP_SEL_B_IMM;
        // Step 0 writes the link address; step 1 forms the target.
        if (step_i == 3'd0) begin
          ctrl.rf_we    = 1'b1;
          ctrl.op_a_sel = ALU_OP_SEL_A_PC;
          imm_sel       = IMM_PCINC;
        end else begin
          ctrl.op_a_sel = (opcode == OPCODE_JAL) ? ALU_OP_SEL_A_PC : ALU_OP_SEL_A_RF;
          imm_sel       = (opcode == OPCODE_JAL) ? IMM_UJ : IMM_I;
        end
      end
      OPCODE_BRANCH: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        num_steps   = 4'(BRANCH_STEPS);
        ctrl.branch = 1'b1;
        case (funct3)
          FUNCT3_BEQ:  ctrl.alu_op = ALU_EQ;
          FUNCT3_BNE:  ctrl.alu_op = ALU_NE;
          FUNCT3_BLT:  ctrl.alu_op = ALU_LT;
          FUNCT3_BGE:  ctrl.alu_op = ALU_GE;
          FUNCT3_BLTU: ctrl.alu_op = ALU_LTU;
          FUNCT3_BGEU: ctrl.alu_op = ALU_GEU;
          default:     bad_enc = 1'b1;
        endcase
        if (step_i != 3'd0) begin
          ctrl.alu_op   = ALU_ADD;
          ctrl.op_a_sel = ALU_OP_SEL_A_PC;
          ctrl.op_b_sel = ALU_OP_SEL_B_IMM;
          imm_sel       = IMM_SB;
        end
      end
      OPCODE_CUSTOM0: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        use_rs3       = 1'b1;
        use_rd        = 1'b1;
        num_steps     = 4'(MM_STEPS);
        ctrl.mm_start = 1'b1;
        case (step_i)
          3'd0:    rs2_sel = rs2;
          3'd1:    rs2_sel = rs3;
          3'd2:    rs2_sel = rs1;
          default: rs2_sel = rd;
        endcase
      end
      default: bad_enc = 1'b1;
    endcase
  end

  assign reg_oob = (use_rs1 && (32'(rs1) >= REG_COUNT)) || (use_rs2 && (32'(rs2) >= REG_COUNT)) ||
                   (use_rd  && (32'(rd)  >= REG_COUNT)) || (use_rs3 && (32'(rs3) >= REG_COUNT));
  assign illegal = bad_enc | reg_oob | (compressed_i & illegal_compressed_i);

  always_comb begin
    case (imm_sel)
      IMM_I:     imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:     imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_SB:    imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:     imm32 = {instr_i[31:12], 12'b0};
      IMM_UJ:    imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      IMM_ZIMM:  imm32 = {27'b0, rs1};
      IMM_PCINC: imm32 = compressed_i ? 32'd2 : 32'd4;
      default:   imm32 = 32'd0;
    endcase
  end

  always_comb begin
    ctrl_o      = ctrl;
    imm_o       = XLEN'($signed(imm32));
    num_steps_o = num_steps;
    if (illegal) begin
      ctrl_o         = '0;
      ctrl_o.illegal = 1'b1;
      imm_o          = '0;
      num_steps_o    = 4'd1;
    end
  end

  assign rs1_addr_o = rs1;
  assign rs2_addr_o = rs2_sel;
  assign rd_addr_o  = rd;

endmodule

// File: rtl/decode_sequencer.sv
// Decode stage: holds one fetched instruction and issues its uops under valid/ready handshakes.
// M-extension decode is enabled by defining DECODE_M_EXT_EN.
module decode_sequencer
  import decode_sequencer_pkg::*;
#(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned MM_STEPS  = 4,
  parameter int unsigned XLEN      = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [XLEN-1:0]              instr_i,
  input  logic                         compressed_i,
  input  logic                         illegal_compressed_i,
  input  logic                         instr_valid_i,
  output logic                         instr_ready_o,
  output logic                         uop_valid_o,
  input  logic                         uop_ready_i,
  output logic [2:0]                   uop_step_o,
  output logic                         uop_last_o,
  input  logic                         branch_taken_i,
  input  logic                         flush_i,
  output logic [$clog2(REG_COUNT)-1:0] rs1_addr_o,
  output logic [$clog2(REG_COUNT)-1:0] rs2_addr_o,
  output logic [$clog2(REG_COUNT)-1:0] rd_addr_o,
  output logic                         rf_we_o,
  output logic [1:0]                   rf_write_sel_o,
  output logic [ALU_OP_WIDTH-1:0]      alu_op_o,
  output logic [1:0]                   op_a_sel_o,
  output logic                         op_b_sel_o,
  output logic [XLEN-1:0]              imm_o,
  output logic                         lsu_w_en_o,
  output logic                         lsu_r_en_o,
  output logic [1:0]                   lsu_data_type_o,
  output logic                         lsu_sign_extend_o,
  output logic [1:0]                   csr_op_o,
  output logic [11:0]                  csr_addr_o,
  output logic                         mm_start_o,
  output logic                         jump_o,
  output logic                         branch_o,
  output logic                         ecall_o,
  output logic                         ebreak_o,
  output logic                         mret_o,
  output logic                         illegal_o
);

  localparam int unsigned RegAw = $clog2(REG_COUNT);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            compressed_q, compressed_d;
  logic            ill_c_q, ill_c_d;
  logic [2:0]      step_q, step_d;

  ctrl_t           ctrl, ctrl_out;
  logic [4:0]      rs1_full, rs2_full, rd_full;
  logic [XLEN-1:0] imm;
  logic [3:0]      num_steps;
  logic            valid, last, fire, accept;

  uop_decode #(
    .REG_COUNT(REG_COUNT),
    .MM_STEPS (MM_STEPS),
    .XLEN     (XLEN)
  ) u_uop_decode (
    .instr_i             (instr_q),
    .step_i              (step_q),
    .compressed_i        (compressed_q),
    .illegal_compressed_i(ill_c_q),
    .ctrl_o              (ctrl),
    .rs1_addr_o          (rs1_full),
    .rs2_addr_o          (rs2_full),
    .rd_addr_o           (rd_full),
    .imm_o               (imm),
    .num_steps_o         (num_steps)
  );

  // Branch step 0 ends the sequence unless execute reports the branch taken.
  always_comb begin
    if (ctrl.branch && (step_q == 3'd0)) begin
      last = ~branch_taken_i;
    end else begin
      last = ({1'b0, step_q} == (num_steps - 4'd1));
    end
  end

  assign valid         = rst_ni & (state_q == ST_ISSUE);
  assign fire          = valid & uop_ready_i;
  assign instr_ready_o = rst_ni & ~flush_i & ((state_q == ST_IDLE) | (fire & last));
  assign accept        = instr_valid_i & instr_ready_o;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    compressed_d = compressed_q;
    ill_c_d      = ill_c_q;
    step_d       = step_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      step_d  = 3'd0;
    end else if (accept) begin
      state_d      = ST_ISSUE;
      instr_d      = instr_i;
      compressed_d = compressed_i;
      ill_c_d      = illegal_compressed_i;
      step_d       = 3'd0;
    end else if (fire) begin
      if (last) begin
        state_d = ST_IDLE;
        step_d  = 3'd0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      compressed_q <= 1'b0;
      ill_c_q      <= 1'b0;
      step_q       <= 3'd0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      compressed_q <= compressed_d;
      ill_c_q      <= ill_c_d;
      step_q       <= step_d;
    end
  end

  assign ctrl_out          = valid ? ctrl : '0;
  assign uop_valid_o       = valid;
  assign uop_step_o        = valid ? step_q : 3'd0;
  assign uop_last_o        = valid & last;
  assign rs1_addr_o        = valid ? rs1_full[RegAw-1:0] : '0;
  assign rs2_addr_o        = valid ? rs2_full[RegAw-1:0] : '0;
  assign rd_addr_o         = valid ? rd_full[RegAw-1:0] : '0;
  assign imm_o             = valid ? imm : '0;
  assign rf_we_o           = ctrl_out.rf_we;
  assign rf_write_sel_o    = ctrl_out.rf_write_sel;
  assign alu_op_o          = ctrl_out.alu_op;
  assign op_a_sel_o        = ctrl_out.op_a_sel;
  assign op_b_sel_o        = ctrl_out.op_b_sel;
  assign lsu_w_en_o        = ctrl_out.lsu_w_en;
  assign lsu_r_en_o        = ctrl_out.lsu_r_en;
  assign lsu_data_type_o   = ctrl_out.lsu_data_type;
  assign lsu_sign_extend_o = ctrl_out.lsu_sign_extend;
  assign csr_op_o          = ctrl_out.csr_op;
  assign csr_addr_o        = ctrl_out.csr_addr;
  assign mm_start_o        = ctrl_out.mm_start;
  assign jump_o            = ctrl_out.jump;
  assign branch_o          = ctrl_out.branch;
  assign ecall_o           = ctrl_out.ecall;
  assign ebreak_o          = ctrl_out.ebreak;
  assign mret_o            = ctrl_out.mret;
  assign illegal_o         = ctrl_out.illegal;

endmodule
